// File: rtl/regfile_dual_pkg.sv
// rtl/regfile_dual_pkg.sv - shared widths and writeback slot layout for the GPR/HILO file
package regfile_dual_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int HILO_WD     = 2 + 2 * RF_DATA_W;
    localparam int WB_TO_RF_WD = HILO_WD + 1 + RF_ADDR_W + RF_DATA_W;

    typedef struct packed {
        logic                 hi_we;
        logic                 lo_we;
        logic [RF_DATA_W-1:0] hi_wdata;
        logic [RF_DATA_W-1:0] lo_wdata;
    } hilo_bus_t;

    // Field order mirrors the writeback stage's slot concatenation, MSB first.
    typedef struct packed {
        hilo_bus_t            hilo;
        logic                 we;
        logic [RF_ADDR_W-1:0] waddr;
        logic [RF_DATA_W-1:0] wdata;
    } wb_slot_t;

    function automatic logic gpr_write_hits(input wb_slot_t slot, input logic [RF_ADDR_W-1:0] addr);
        return slot.we && (slot.waddr != '0) && (slot.waddr == addr);
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - HI/LO pair with independent per-half writes, younger slot wins
// Optional write-through forwarding under RF_WRITE_BYPASS_EN.
module hilo_reg
    import regfile_dual_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  hilo_bus_t            hilo_i1_i,
    input  hilo_bus_t            hilo_i2_i,
    output logic [RF_DATA_W-1:0] hi_o,
    output logic [RF_DATA_W-1:0] lo_o
);

    logic [RF_DATA_W-1:0] hi_q, hi_d;
    logic [RF_DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hilo_i1_i.hi_we) hi_d = hilo_i1_i.hi_wdata;
        if (hilo_i2_i.hi_we) hi_d = hilo_i2_i.hi_wdata;
        if (hilo_i1_i.lo_we) lo_d = hilo_i1_i.lo_wdata;
        if (hilo_i2_i.lo_we) lo_d = hilo_i2_i.lo_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef RF_WRITE_BYPASS_EN
    assign hi_o = rst ? '0 : hi_d;
    assign lo_o = rst ? '0 : lo_d;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: rtl/regfile_dual.sv
// rtl/regfile_dual.sv - dual-write, quad-read GPR file plus HI/LO fed by the writeback bus
// Optional same-cycle write forwarding under RF_WRITE_BYPASS_EN.
module regfile_dual
    import regfile_dual_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [RF_ADDR_W-1:0]     raddr1,
    input  logic [RF_ADDR_W-1:0]     raddr2,
    input  logic [RF_ADDR_W-1:0]     raddr3,
    input  logic [RF_ADDR_W-1:0]     raddr4,
    output logic [DATA_W-1:0]        rdata1,
    output logic [DATA_W-1:0]        rdata2,
    output logic [DATA_W-1:0]        rdata3,
    output logic [DATA_W-1:0]        rdata4,
    output logic [DATA_W-1:0]        hi_o,
    output logic [DATA_W-1:0]        lo_o
);

    wb_slot_t slot_i1, slot_i2;
    assign slot_i1 = wb_slot_t'(wb_to_rf_bus[WB_TO_RF_WD-1:0]);
    assign slot_i2 = wb_slot_t'(wb_to_rf_bus[2*WB_TO_RF_WD-1:WB_TO_RF_WD]);

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [DATA_W-1:0] gpr_d [NREG];

    // i2 is applied last so the younger instruction wins a same-address conflict.
    always_comb begin
        gpr_d = gpr_q;
        if (slot_i1.we && slot_i1.waddr != '0) gpr_d[slot_i1.waddr] = slot_i1.wdata;
        if (slot_i2.we && slot_i2.waddr != '0) gpr_d[slot_i2.waddr] = slot_i2.wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else begin
            gpr_q <= gpr_d;
        end
    end

    logic [RF_ADDR_W-1:0] raddr_a [4];
    logic [DATA_W-1:0]    rdata_a [4];

    assign raddr_a[0] = raddr1;
    assign raddr_a[1] = raddr2;
    assign raddr_a[2] = raddr3;
    assign raddr_a[3] = raddr4;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata_a[p] = '0;
            if (!rst && raddr_a[p] != '0) begin
                rdata_a[p] = gpr_q[raddr_a[p]];
`ifdef RF_WRITE_BYPASS_EN
                if (gpr_write_hits(slot_i1, raddr_a[p])) rdata_a[p] = slot_i1.wdata;
                if (gpr_write_hits(slot_i2, raddr_a[p])) rdata_a[p] = slot_i2.wdata;
`endif
            end
        end
    end

    assign rdata1 = rdata_a[0];
    assign rdata2 = rdata_a[1];
    assign rdata3 = rdata_a[2];
    assign rdata4 = rdata_a[3];

    hilo_reg u_hilo_reg (
        .clk       (clk),
        .rst       (rst),
        .hilo_i1_i (slot_i1.hilo),
        .hilo_i2_i (slot_i2.hilo),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

endmodule
